// File: rtl/bit_serial_alu_ctrl.sv
// Bit-serial ALU sequencer: runs a 1-bit slice LSB first, one bit/clock.
// Ports: start/op/a/b in; ready/busy/done, result/c_out/zero out.
module bit_serial_alu_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [2:0] OP_NOT  = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b011;
  localparam logic [2:0] OP_NOR  = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;
  localparam logic [2:0] OP_ADD  = 3'b110;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  // result bits collect here; the MSB arrives on the last edge
  logic [WIDTH-2:0] res_sr_q, res_sr_d;
  logic [2:0]       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             c_out_q, c_out_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;

  logic             a_i, b_i, b_eff;
  logic             is_add, is_sub, is_arith;
  logic             is_not, is_nand, is_nor;
  logic             sum, cy, slice_bit;
  logic [WIDTH-1:0] res_shift;
  logic             last;

  assign a_i      = a_sr_q[0];
  assign b_i      = b_sr_q[0];
  assign is_add   = (op_q == OP_ADD);
  assign is_sub   = (op_q == OP_SUB);
  assign is_arith = is_add | is_sub;
  assign is_not   = (op_q == OP_NOT);
  assign is_nand  = (op_q == OP_NAND);
  assign is_nor   = (op_q == OP_NOR);

  // SUB is a + ~b + 1; the +1 comes from the preset carry
  assign b_eff = is_sub ? ~b_i : b_i;
  assign sum   = a_i ^ b_eff ^ carry_q;
  assign cy    = (a_i & b_eff) | (a_i & carry_q)
               | (b_eff & carry_q);

  always_comb begin
    slice_bit = a_i;
    unique case (1'b1)
      is_arith: slice_bit = sum;
      is_not:   slice_bit = ~a_i;
      is_nand:  slice_bit = ~(a_i & b_i);
      is_nor:   slice_bit = ~(a_i | b_i);
      default:  slice_bit = a_i;
    endcase
  end

  assign res_shift = {slice_bit, res_sr_q};
  assign last      = (cnt_q == LAST);

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_sr_d = res_sr_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    result_d = result_q;
    c_out_d  = c_out_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    busy_d   = busy_q;
    ready_d  = ready_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_RUN;
          a_sr_d   = a;
          b_sr_d   = b;
          res_sr_d = '0;
          op_d     = op;
          cnt_d    = '0;
          carry_d  = (op == OP_SUB);
          busy_d   = 1'b1;
          ready_d  = 1'b0;
        end else begin
          state_d  = S_IDLE;
          busy_d   = 1'b0;
          ready_d  = 1'b1;
        end
      end
      S_RUN: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        res_sr_d = res_shift[WIDTH-1:1];
        carry_d  = is_arith & cy;
        cnt_d    = cnt_q + CNT_W'(1);
        if (last) begin
          state_d  = S_DONE;
          result_d = res_shift;
          c_out_d  = is_arith & cy;
          zero_d   = (res_shift == '0);
          done_d   = 1'b1;
          busy_d   = 1'b0;
          ready_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      c_out_q  <= 1'b0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      c_out_q  <= c_out_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
    end
  end

  assign ready  = ready_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign c_out  = c_out_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// Testbench for bit_serial_alu_ctrl: vector table, corner sequences,
// and random ops against an arithmetic reference model.
module tb_bit_serial_alu_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         ready, busy, done;
  logic [W-1:0] result;
  logic         c_out, zero;

  int n_chk = 0;
  int n_fail = 0;

  bit_serial_alu_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .op(op), .a(a), .b(b),
    .ready(ready), .busy(busy), .done(done),
    .result(result), .c_out(c_out), .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    logic         c;
    logic         z;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // {zero, carry, result} computed with plain arithmetic
  function automatic logic [W+1:0] model(input logic [2:0] o,
                                         input logic [W-1:0] x,
                                         input logic [W-1:0] y);
    logic [W:0]   s;
    logic [W-1:0] r;
    logic         c;
    c = 1'b0;
    case (o)
      3'b110: begin s = {1'b0, x} + {1'b0, y}; r = s[W-1:0]; c = s[W]; end
      3'b101: begin r = x - y; c = (x >= y); end
      3'b001: r = ~x;
      3'b011: r = ~(x & y);
      3'b100: r = ~(x | y);
      default: r = x;
    endcase
    return {(r == '0), c, r};
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, output logic [W-1:0] r,
                        output logic c, output logic z, output int lat);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!done) chk("done_timeout", 0, 1);
    r = result; c = c_out; z = zero;
  endtask

  initial begin
    logic [W-1:0] r;
    logic         c, z;
    logic [W+1:0] m;
    int           lat, k, bad, ndone;

    tbl[0]  = '{3'b110, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0};
    tbl[1]  = '{3'b110, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1};
    tbl[2]  = '{3'b101, 8'h07, 8'h05, 8'h02, 1'b1, 1'b0};
    tbl[3]  = '{3'b101, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0};
    tbl[4]  = '{3'b011, 8'hF0, 8'hCC, 8'h3F, 1'b0, 1'b0};
    tbl[5]  = '{3'b100, 8'hF0, 8'h0F, 8'h00, 1'b0, 1'b1};
    tbl[6]  = '{3'b001, 8'hA5, 8'hFF, 8'h5A, 1'b0, 1'b0};
    tbl[7]  = '{3'b000, 8'h3C, 8'hFF, 8'h3C, 1'b0, 1'b0};
    tbl[8]  = '{3'b010, 8'h96, 8'hFF, 8'h96, 1'b0, 1'b0};
    tbl[9]  = '{3'b111, 8'h96, 8'hFF, 8'h96, 1'b0, 1'b0};
    tbl[10] = '{3'b101, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1};
    tbl[11] = '{3'b110, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};

    #12;
    chk("rst_result", int'(result), 0);
    chk("rst_c_out", int'(c_out), 0);
    chk("rst_zero", int'(zero), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, r, c, z, lat);
      chk($sformatf("vec%0d_result", i), int'(r), int'(tbl[i].r));
      chk($sformatf("vec%0d_c_out", i), int'(c), int'(tbl[i].c));
      chk($sformatf("vec%0d_zero", i), int'(z), int'(tbl[i].z));
      chk($sformatf("vec%0d_latency", i), lat, W);
    end

    // result/flags hold through the next op's RUN
    run_op(3'b110, 8'h7F, 8'h01, r, c, z, lat);
    op = 3'b001; a = 8'hA5; b = 8'h00; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("hold_busy", int'(busy), 1);
    bad = 0; k = 0;
    while (!done && k < 40) begin
      if (result != 8'h80 || c_out || zero) bad++;
      @(posedge clk); #1;
      k++;
    end
    chk("hold_stable", bad, 0);
    chk("hold_new_result", int'(result), 8'h5A);

    // start held high through RUN, then back-to-back accept in DONE
    op = 3'b110; a = 8'h7F; b = 8'h01; start = 1'b1;
    @(posedge clk); #1;
    op = 3'b101; a = 8'h05; b = 8'h07;
    k = 0; bad = 0;
    while (!done && k < 40) begin
      if (!busy || ready) bad++;
      @(posedge clk); #1;
      k++;
    end
    chk("b2b_busy_in_run", bad, 0);
    chk("b2b_first_lat", k, W);
    chk("b2b_first_result", int'(result), 8'h80);
    chk("b2b_first_c_out", int'(c_out), 0);
    chk("b2b_ready_in_done", int'(ready), 1);
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_accepted", int'(busy), 1);
    k = 1;
    while (!done && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    chk("b2b_done_gap", k, W + 1);
    chk("b2b_second_result", int'(result), 8'hFE);
    chk("b2b_second_c_out", int'(c_out), 0);

    // reset in the middle of ADD 0xFF+0x01
    op = 3'b110; a = 8'hFF; b = 8'h01; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_result", int'(result), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_ready", int'(ready), 1);
    chk("abort_done", int'(done), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ndone = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    run_op(3'b110, 8'hFF, 8'h01, r, c, z, lat);
    chk("after_abort_result", int'(r), 0);
    chk("after_abort_c_out", int'(c), 1);
    chk("after_abort_zero", int'(z), 1);

    for (int i = 0; i < 200; i++) begin
      logic [2:0]   ro;
      logic [W-1:0] ra, rb;
      ro = 3'($urandom_range(0, 7));
      ra = W'($urandom);
      rb = W'($urandom);
      m  = model(ro, ra, rb);
      run_op(ro, ra, rb, r, c, z, lat);
      chk($sformatf("rnd%0d_op%0d_%0h_%0h", i, ro, ra, rb),
          int'({z, c, r}), int'(m));
      chk($sformatf("rnd%0d_latency", i), lat, W);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
